// File: rtl/shared_add_sequencer.sv
// shared_add_sequencer
// Two requesters share one narrow slice adder. A round-robin arbiter grants
// one operation at a time; the adder then walks the operands SLICE bits per
// cycle, and the finished sum is held in a response register until the
// consumer accepts it.
module shared_add_sequencer #(
  parameter int WIDTH = 64,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  // response
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state;
  logic             ptr;        // requester that wins when both are valid
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_work;   // partial sum, filled one slice per cycle
  logic             carry;
  logic             id_reg;
  logic [CW-1:0]    k;          // index of the slice added this cycle

  logic             grant_valid;
  logic             grant_id;
  logic             take;
  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] sum_next;

  // Arbitration: a lone requester wins outright, a tie goes to the pointer.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = ptr;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  // Ready is combinational so the handshake completes in the grant cycle;
  // it is masked during reset so nothing is accepted while rst is high.
  assign take       = (state == IDLE) && grant_valid && !rst;
  assign req0_ready = take && !grant_id;
  assign req1_ready = take && grant_id;
  assign busy       = (state != IDLE);

  // Slice adder: current slice of both operands plus the running carry,
  // merged into the partial sum at the slice position.
  always_comb begin
    slice_sum = {1'b0, a_reg[int'(k)*SLICE +: SLICE]}
              + {1'b0, b_reg[int'(k)*SLICE +: SLICE]}
              + {{SLICE{1'b0}}, carry};
    sum_next  = sum_work;
    sum_next[int'(k)*SLICE +: SLICE] = slice_sum[SLICE-1:0];
  end

  // Sequencer FSM with registered response outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: the operand and partial-sum registers are reset as well; the cost is
  // small and it keeps every register value defined right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_work  <= '0;
      carry     <= 1'b0;
      id_reg    <= 1'b0;
      k         <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            a_reg  <= grant_id ? req1_a   : req0_a;
            b_reg  <= grant_id ? req1_b   : req0_b;
            carry  <= grant_id ? req1_cin : req0_cin;
            id_reg <= grant_id;
            ptr    <= ~grant_id;
            k      <= '0;
            state  <= ADD;
          end
        end
        ADD: begin
          sum_work <= sum_next;
          carry    <= slice_sum[SLICE];
          k        <= k + 1'b1;
          if (k == LAST) begin
            // Response registers change only here, so the previous result
            // stays visible for the whole next operation.
            rsp_valid <= 1'b1;
            rsp_sum   <= sum_next;
            rsp_cout  <= slice_sum[SLICE];
            rsp_id    <= id_reg;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_add_sequencer.sv
// Self-checking bench for shared_add_sequencer: directed corner cases plus
// randomized operations compared against an arithmetic reference model.
module tb_shared_add_sequencer;

  localparam int WIDTH = 64;
  localparam int SLICE = 8;
  localparam int NSL   = WIDTH / SLICE;
  localparam int LAT   = NSL + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             req0_cin = 1'b0, req1_cin = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout, rsp_id, busy;

  always #5 clk = ~clk;

  shared_add_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy)
  );

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             id;
  } rsp_t;

  int n_vec = 0;
  int n_err = 0;

  // Last accepted response; the DUT must keep showing it until the next one.
  logic [WIDTH-1:0] last_sum  = '0;
  logic             last_cout = 1'b0;
  logic             last_id   = 1'b0;

  // Reference: plain wide addition.
  function automatic rsp_t model(input logic id, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic cin);
    rsp_t r;
    logic [WIDTH:0] t;
    t      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    r.sum  = t[WIDTH-1:0];
    r.cout = t[WIDTH];
    r.id   = id;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  task automatic drive_req(input logic id, input logic v, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic c);
    if (id == 1'b0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_cin = c;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_cin = c;
    end
  endtask

  // One complete transaction from one requester with inline checks on grant,
  // latency, result, hold during stall, and retention after handshake.
  task automatic run_op(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input int stall, input string tag);
    rsp_t exp;
    int   lat;
    int   waitc;
    bit   seen;
    exp = model(id, a, b, cin);
    @(negedge clk);
    drive_req(id, 1'b1, a, b, cin);
    #1;
    waitc = 0;
    while (!(id ? req1_ready : req0_ready) && waitc < 20) begin
      @(negedge clk); #1;
      waitc++;
    end
    n_vec++;
    if (waitc >= 20) begin
      n_err++;
      $display("FAIL %s grant: ready got 0 want 1", tag);
      drive_req(id, 1'b0, '0, '0, 1'b0);
      return;
    end
    n_vec++;
    if ((id ? req0_ready : req1_ready) !== 1'b0) begin
      n_err++;
      $display("FAIL %s other_ready: got 1 want 0", tag);
    end
    @(posedge clk); #1;
    // Garbage with valid high while busy must be ignored.
    drive_req(id, 1'b1, rand_word(), rand_word(), 1'($urandom));
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 3 * LAT) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) seen = 1'b1;
      else begin
        n_vec++;
        if (busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
            rsp_sum !== last_sum || rsp_cout !== last_cout || rsp_id !== last_id) begin
          n_err++;
          $display("FAIL %s add_phase: busy=%b rdy=%b%b sum=%h cout=%b id=%b want busy=1 rdy=00 sum=%h cout=%b id=%b",
                   tag, busy, req0_ready, req1_ready, rsp_sum, rsp_cout, rsp_id, last_sum, last_cout, last_id);
        end
        if (lat == 5) drive_req(id, 1'b0, '0, '0, 1'b0);
      end
    end
    n_vec++;
    if (!seen || lat != LAT) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", tag, seen ? lat : -1, LAT);
    end
    drive_req(id, 1'b0, '0, '0, 1'b0);
    if (!seen) return;
    n_vec++;
    if (rsp_sum !== exp.sum) begin
      n_err++;
      $display("FAIL %s sum: got %h want %h", tag, rsp_sum, exp.sum);
    end
    n_vec++;
    if (rsp_cout !== exp.cout || rsp_id !== exp.id) begin
      n_err++;
      $display("FAIL %s cout_id: got %b/%b want %b/%b", tag, rsp_cout, rsp_id, exp.cout, exp.id);
    end
    // The other requester asks during DONE; it must not be granted.
    drive_req(!id, 1'b1, rand_word(), rand_word(), 1'($urandom));
    for (int i = 0; i < stall; i++) begin
      #1;
      n_vec++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s done_grant: rdy=%b%b want 00", tag, req0_ready, req1_ready);
      end
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_sum !== exp.sum || rsp_cout !== exp.cout || rsp_id !== exp.id) begin
        n_err++;
        $display("FAIL %s stall_hold: valid=%b sum=%h want valid=1 sum=%h", tag, rsp_valid, rsp_sum, exp.sum);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_vec++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s handshake_grant: rdy=%b%b want 00", tag, req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive_req(!id, 1'b0, '0, '0, 1'b0);
    n_vec++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s release: valid=%b busy=%b want 0/0", tag, rsp_valid, busy);
    end
    n_vec++;
    if (rsp_sum !== exp.sum || rsp_cout !== exp.cout || rsp_id !== exp.id) begin
      n_err++;
      $display("FAIL %s retain: sum=%h want %h", tag, rsp_sum, exp.sum);
    end
    last_sum  = exp.sum;
    last_cout = exp.cout;
    last_id   = exp.id;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_req(1'b0, 1'b1, rand_word(), rand_word(), 1'b1);
    drive_req(1'b1, 1'b1, rand_word(), rand_word(), 1'b1);
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
    end
    n_vec++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: valid=%b busy=%b want 0/0", rsp_valid, busy);
    end
    n_vec++;
    if (rsp_sum !== '0 || rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin
      n_err++;
      $display("FAIL reset_rsp: sum=%h cout=%b id=%b want 0", rsp_sum, rsp_cout, rsp_id);
    end
    drive_req(1'b0, 1'b0, '0, '0, 1'b0);
    drive_req(1'b1, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    last_sum = '0; last_cout = 1'b0; last_id = 1'b0;
  endtask

  task automatic test_directed();
    run_op(1'b0, '1, 64'd1, 1'b0, 0, "all_ones_plus_one");
    run_op(1'b1, '0, '0, 1'b1, 0, "cin_only");
    run_op(1'b0, 64'h00FF00FF00FF00FF, 64'h0001000100010001, 1'b0, 1, "slice_carry");
  endtask

  task automatic test_alternate();
    rsp_t             q[$];
    rsp_t             exp;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             c0, c1, expect_id, gid;
    int               grants, cyc, chg;
    @(negedge clk);
    rst = 1'b1;
    a0 = rand_word(); b0 = rand_word(); c0 = 1'($urandom);
    a1 = rand_word(); b1 = rand_word(); c1 = 1'($urandom);
    drive_req(1'b0, 1'b1, a0, b0, c0);
    drive_req(1'b1, 1'b1, a1, b1, c1);
    @(negedge clk);
    rst = 1'b0;
    last_sum = '0; last_cout = 1'b0; last_id = 1'b0;
    rsp_ready = 1'b1;
    expect_id = 1'b0;
    grants = 0; cyc = 0; chg = -1;
    // The first cycle after release is sampled here too.
    while ((grants < 4 || q.size() > 0) && cyc < 200) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (grants >= 4) begin
        drive_req(1'b0, 1'b0, a0, b0, c0);
        drive_req(1'b1, 1'b0, a1, b1, c1);
      end else if (chg == 0) begin
        a0 = rand_word(); b0 = rand_word(); c0 = 1'($urandom);
        drive_req(1'b0, 1'b1, a0, b0, c0);
      end else if (chg == 1) begin
        a1 = rand_word(); b1 = rand_word(); c1 = 1'($urandom);
        drive_req(1'b1, 1'b1, a1, b1, c1);
      end
      chg = -1;
      #1;
      n_vec++;
      if (req0_ready && req1_ready) begin
        n_err++;
        $display("FAIL alt_both_ready: got 11 want at most one");
      end
      if (req0_ready || req1_ready) begin
        gid = req1_ready;
        n_vec++;
        if (gid !== expect_id) begin
          n_err++;
          $display("FAIL alt_grant_order: got %b want %b", gid, expect_id);
        end
        q.push_back(gid ? model(1'b1, a1, b1, c1) : model(1'b0, a0, b0, c0));
        expect_id = ~expect_id;
        grants++;
        chg = int'(gid);
      end
      if (rsp_valid) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL alt_unexpected_rsp: got valid=1 want 0");
        end else begin
          exp = q.pop_front();
          if (rsp_sum !== exp.sum || rsp_cout !== exp.cout || rsp_id !== exp.id) begin
            n_err++;
            $display("FAIL alt_rsp: sum=%h cout=%b id=%b want sum=%h cout=%b id=%b",
                     rsp_sum, rsp_cout, rsp_id, exp.sum, exp.cout, exp.id);
          end
          last_sum = exp.sum; last_cout = exp.cout; last_id = exp.id;
        end
      end
    end
    n_vec++;
    if (cyc >= 200) begin
      n_err++;
      $display("FAIL alt_timeout: got %0d grants %0d pending want 4/0", grants, q.size());
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive_req(1'b0, 1'b0, '0, '0, 1'b0);
    drive_req(1'b1, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_stall();
    run_op(1'b1, rand_word(), rand_word(), 1'($urandom), 5, "stall5");
  endtask

  task automatic test_reset_abort();
    int waitc;
    @(negedge clk);
    drive_req(1'b0, 1'b1, rand_word(), rand_word(), 1'b0);
    #1;
    waitc = 0;
    while (!req0_ready && waitc < 20) begin
      @(negedge clk); #1;
      waitc++;
    end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, '0, '0, 1'b0);
    repeat (4) @(negedge clk);        // middle of the 4th ADD cycle
    rst = 1'b1;
    drive_req(1'b0, 1'b1, rand_word(), rand_word(), 1'b1);
    drive_req(1'b1, 1'b1, rand_word(), rand_word(), 1'b1);
    #1;
    n_vec++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL abort_in_reset: busy=%b valid=%b rdy=%b%b want all 0", busy, rsp_valid, req0_ready, req1_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_req(1'b0, 1'b0, '0, '0, 1'b0);
    drive_req(1'b1, 1'b0, '0, '0, 1'b0);
    last_sum = '0; last_cout = 1'b0; last_id = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_sum !== '0) begin
        n_err++;
        $display("FAIL abort_quiet: valid=%b busy=%b sum=%h want 0/0/0", rsp_valid, busy, rsp_sum);
      end
    end
    run_op(1'b1, rand_word(), rand_word(), 1'b0, 0, "after_abort");
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b;
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 3))
        0:       begin a = '1;          b = WIDTH'($urandom_range(0, 3)); end
        1:       begin a = rand_word(); b = ~a;                           end
        default: begin a = rand_word(); b = rand_word();                  end
      endcase
      run_op(1'($urandom), a, b, 1'($urandom), int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_alternate();
    test_stall();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shared_add_sequencer.md
SHARED_ADD_SEQUENCER -- requirements
Module: shared_add_sequencer

Interface
REQ-001 Parameter WIDTH, default 64, operand/sum width in bits; SHALL be an integer multiple of SLICE.
REQ-002 Parameter SLICE, default 8, bits added per cycle by the internal slice adder.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-008 req0_cin  input  1  requester 0 carry-in.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_cin: same directions, widths and meanings for requester 1.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
REQ-013 rsp_cout  output  1  carry out of bit WIDTH-1.
REQ-014 rsp_id  output  1  index of the requester that owns the result.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ADD and DONE.
REQ-017 IDLE: if only one valid is high, that requester SHALL be granted; if both are high, the requester named by the round-robin pointer SHALL be granted.
REQ-018 After any grant, the pointer SHALL point to the non-granted requester.
REQ-019 reqN_ready SHALL be combinational: high only in IDLE, with reqN granted, and rst low; at most one ready high per cycle.
REQ-020 In the handshake cycle the unit SHALL latch a, b, the requester id and cin (cin into the carry register), clear the slice counter, and enter ADD.
REQ-021 ADD: each cycle the unit SHALL add slice k of a and b plus the carry register, write bits [k*SLICE +: SLICE] of the sum register, update the carry, and increment k.
REQ-022 After the slice with k = WIDTH/SLICE-1 is added, the FSM SHALL enter DONE.
REQ-023 DONE: rsp_valid SHALL be high and rsp_sum, rsp_cout and rsp_id SHALL remain stable until rsp_ready is high.
REQ-024 On rsp_valid and rsp_ready both high, the FSM SHALL return to IDLE; no new request SHALL be accepted in that same cycle.
REQ-025 Latency: handshake at cycle N, rsp_valid first high at cycle N + WIDTH/SLICE + 1 (N+9 with defaults).
REQ-026 Overflow SHALL wrap modulo 2^WIDTH, with the carry reported on rsp_cout; no other status is produced.
REQ-027 Requester inputs SHALL be ignored outside IDLE; a requester dropping valid before a grant SHALL lose nothing.
REQ-028 rsp_sum, rsp_cout and rsp_id SHALL retain their last values after the response handshake until the next operation completes.

Reset
REQ-029 While rst is high, the unit SHALL hold state = IDLE, pointer = requester 0, rsp_valid = 0, rsp_sum = 0, rsp_cout = 0, rsp_id = 0, busy = 0, req0_ready = req1_ready = 0.
REQ-030 Reset asserted in ADD or DONE SHALL abort the operation with no response; the first cycle after release SHALL be IDLE.

Verification
REQ-031 req0: a = all-ones, b = 1, cin = 0 -> rsp_sum = 0, rsp_cout = 1, rsp_id = 0, rsp_valid at N+9.
REQ-032 req1: a = 0, b = 0, cin = 1 -> rsp_sum = 1, rsp_cout = 0, rsp_id = 1.
REQ-033 Both valid continuously from reset release -> grants alternate 0, 1, 0, 1; rsp_id sequence matches; ready is never high for both in one cycle.
REQ-034 rsp_ready held low for 5 cycles in DONE -> rsp_valid stays high and outputs stay stable; no new grant until one cycle after the response handshake.
REQ-035 rst pulsed at the 4th ADD cycle -> no rsp_valid; busy = 0; the next request completes correctly with a fresh latency of 9 cycles.
REQ-036 a = 0x00FF00FF00FF00FF, b = 0x0001000100010001, cin = 0 -> rsp_sum = 0x0100010001000100, exercising carry propagation across slice boundaries.
